// File: rtl/bsg_scheduler_resource_tracker_pkg.sv
// Shared types for the resource tracker: per-slot state encoding and a width helper.
package bsg_scheduler_resource_tracker_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'b00,
    SLOT_PENDING = 2'b01,
    SLOT_READY   = 2'b10
  } slot_state_e;

  // Index width that never collapses to zero for single-slot banks.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_scheduler_resource_tracker_if.sv
// Producer/scheduler-facing bundle of the resource tracker; the slave modport is the tracker side.
interface bsg_scheduler_resource_tracker_if #(
  parameter int resources_p    = 2,
  parameter int max_dep_bits_p = 4,
  parameter int refcnt_width_p = 4,
  localparam int dep_width_lp  = bsg_scheduler_resource_tracker_pkg::safe_clog2(max_dep_bits_p)
);

  logic [resources_p-1:0]                     alloc_v_i;
  logic [resources_p-1:0][refcnt_width_p-1:0] alloc_refs_i;
  logic [resources_p-1:0]                     alloc_yumi_o;
  logic [resources_p-1:0][dep_width_lp-1:0]   alloc_idx_o;
  logic [resources_p-1:0]                     done_v_i;
  logic [resources_p-1:0][dep_width_lp-1:0]   done_idx_i;
  logic                                       release_v_i;
  logic [resources_p-1:0]                     release_mask_i;
  logic [resources_p-1:0][dep_width_lp-1:0]   release_idx_i;
  logic [resources_p-1:0][max_dep_bits_p-1:0] res_avail_o;
  logic [resources_p-1:0]                     empty_o;
  logic                                       err_o;

  modport master (
    output alloc_v_i, alloc_refs_i, done_v_i, done_idx_i,
           release_v_i, release_mask_i, release_idx_i,
    input  alloc_yumi_o, alloc_idx_o, res_avail_o, empty_o, err_o
  );

  modport slave (
    input  alloc_v_i, alloc_refs_i, done_v_i, done_idx_i,
           release_v_i, release_mask_i, release_idx_i,
    output alloc_yumi_o, alloc_idx_o, res_avail_o, empty_o, err_o
  );

endinterface

// File: rtl/bsg_scheduler_resource_tracker_bank.sv
// One resource's slot array: lowest-free allocation, completion, release and per-bank error.
// Optional per-slot consumer counts under BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN.
module bsg_scheduler_resource_tracker_bank
  import bsg_scheduler_resource_tracker_pkg::*;
#(
  parameter int max_dep_bits_p = 4,
  parameter int refcnt_width_p = 4,
  localparam int dep_width_lp  = safe_clog2(max_dep_bits_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      alloc_v,
  input  logic [refcnt_width_p-1:0] alloc_refs,
  output logic                      alloc_yumi,
  output logic [dep_width_lp-1:0]   alloc_idx,
  input  logic                      done_v,
  input  logic [dep_width_lp-1:0]   done_idx,
  input  logic                      release_v,
  input  logic [dep_width_lp-1:0]   release_idx,
  output logic [max_dep_bits_p-1:0] avail,
  output logic                      empty,
  output logic                      err
);

  slot_state_e slot_q [max_dep_bits_p];
  slot_state_e slot_d [max_dep_bits_p];

  logic [max_dep_bits_p-1:0] free_vec;
  logic                      bad_state;
  logic                      done_legal;
  logic                      release_legal;
  logic                      release_last;

`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
  logic [refcnt_width_p-1:0] cnt_q [max_dep_bits_p];
  logic [refcnt_width_p-1:0] cnt_d [max_dep_bits_p];
`else
  logic unused_refs;
  assign unused_refs = ^alloc_refs;
`endif

  // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    free_vec  = '0;
    avail     = '0;
    bad_state = 1'b0;
    for (int i = 0; i < max_dep_bits_p; i++) begin
      free_vec[i] = (slot_q[i] == SLOT_FREE);
      avail[i]    = (slot_q[i] == SLOT_READY);
      bad_state   = bad_state | !(slot_q[i] inside {SLOT_FREE, SLOT_PENDING, SLOT_READY});
    end
  end

  assign empty      = &free_vec;
  assign alloc_yumi = alloc_v & (|free_vec);

  // Descending scan so the lowest free slot is the last (winning) assignment.
  always_comb begin
    alloc_idx = '0;
    for (int i = max_dep_bits_p - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = dep_width_lp'(i);
    end
  end

  // Out-of-range indices match no slot and therefore read as illegal.
  always_comb begin
    done_legal    = 1'b0;
    release_legal = 1'b0;
    release_last  = 1'b1;
    for (int i = 0; i < max_dep_bits_p; i++) begin
      if (done_idx == dep_width_lp'(i))
        done_legal = done_v && (slot_q[i] == SLOT_PENDING);
      if (release_idx == dep_width_lp'(i)) begin
        release_legal = release_v && (slot_q[i] == SLOT_READY);
`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
        release_last  = (cnt_q[i] == refcnt_width_p'(1));
`endif
      end
    end
  end

  assign err = (done_v & ~done_legal) | (release_v & ~release_legal) | bad_state;

  // Legal done/release only target non-free slots, so they never collide with the alloc slot.
  always_comb begin
    slot_d = slot_q;
`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
    cnt_d  = cnt_q;
`endif
    for (int i = 0; i < max_dep_bits_p; i++) begin
      if (alloc_yumi && alloc_idx == dep_width_lp'(i)) begin
        slot_d[i] = SLOT_PENDING;
`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
        cnt_d[i]  = (alloc_refs == '0) ? refcnt_width_p'(1) : alloc_refs;
`endif
      end
      if (done_legal && done_idx == dep_width_lp'(i))
        slot_d[i] = SLOT_READY;
      if (release_legal && release_idx == dep_width_lp'(i)) begin
        if (release_last) slot_d[i] = SLOT_FREE;
`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
        cnt_d[i] = cnt_q[i] - refcnt_width_p'(1);
`endif
      end
    end
  end

  // NOTE: the slot array is reset, not left uninitialised, because "all FREE" must be observable straight out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < max_dep_bits_p; i++) slot_q[i] <= SLOT_FREE;
    end else begin
      // NOTE: non-blocking so every slot updates from the same pre-edge view of the array.
      slot_q <= slot_d;
    end
  end

`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < max_dep_bits_p; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: rtl/bsg_scheduler_resource_tracker.sv
// Producer-side tracker: per-resource slot banks feeding the scheduler's readiness bitmaps.
// Consumer reference counting is enabled by defining BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN.
module bsg_scheduler_resource_tracker
  import bsg_scheduler_resource_tracker_pkg::*;
#(
  parameter int resources_p    = 2,
  parameter int max_dep_bits_p = 4,
  parameter int refcnt_width_p = 4,
  localparam int dep_width_lp  = safe_clog2(max_dep_bits_p)
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bsg_scheduler_resource_tracker_if.slave bus
);

  logic [resources_p-1:0]                     yumi;
  logic [resources_p-1:0][dep_width_lp-1:0]   idx;
  logic [resources_p-1:0][max_dep_bits_p-1:0] avail;
  logic [resources_p-1:0]                     empty;
  logic [resources_p-1:0]                     bank_err;
  logic                                       err_q;

  for (genvar r = 0; r < resources_p; r++) begin : g_bank
    bsg_scheduler_resource_tracker_bank #(
      .max_dep_bits_p(max_dep_bits_p),
      .refcnt_width_p(refcnt_width_p)
    ) bank (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .alloc_v    (bus.alloc_v_i[r]),
      .alloc_refs (bus.alloc_refs_i[r]),
      .alloc_yumi (yumi[r]),
      .alloc_idx  (idx[r]),
      .done_v     (bus.done_v_i[r]),
      .done_idx   (bus.done_idx_i[r]),
      .release_v  (bus.release_v_i & bus.release_mask_i[r]),
      .release_idx(bus.release_idx_i[r]),
      .avail      (avail[r]),
      .empty      (empty[r]),
      .err        (bank_err[r])
    );
  end

  // Sticky until reset: any bank's protocol violation latches here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_q | (|bank_err);
  end

  assign bus.alloc_yumi_o = yumi;
  assign bus.alloc_idx_o  = idx;
  assign bus.res_avail_o  = avail;
  assign bus.empty_o      = empty;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_bsg_scheduler_resource_tracker.sv
// Self-checking bench for bsg_scheduler_resource_tracker: vector table, corner sequences, random vs model.
module tb_bsg_scheduler_resource_tracker;

  localparam int R = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bsg_scheduler_resource_tracker_if #(.resources_p(R), .max_dep_bits_p(D), .refcnt_width_p(4)) bus ();

  bsg_scheduler_resource_tracker #(.resources_p(R), .max_dep_bits_p(D), .refcnt_width_p(4)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic [1:0] alloc_v;
    logic [1:0] done_v;
    logic [3:0] done_idx;   // {r1, r0}
    logic       rel_v;
    logic [1:0] rel_mask;
    logic [3:0] rel_idx;    // {r1, r0}
    logic [1:0] exp_yumi;   // same cycle
    logic [7:0] exp_avail;  // after edge, {r1, r0}
    logic [1:0] exp_empty;
    logic [1:0] chk_idx;
    logic [3:0] exp_idx;    // after edge, {r1, r0}
  } vec_t;

  vec_t vecs [15];

  // Reference model: slot contents as plain integers (0 free, 1 awaiting producer, 2 result ready).
  int m_state [R][D];
  int m_cnt   [R][D];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alloc_v_i      = '0;
    bus.alloc_refs_i   = '0;
    bus.done_v_i       = '0;
    bus.done_idx_i     = '0;
    bus.release_v_i    = 1'b0;
    bus.release_mask_i = '0;
    bus.release_idx_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int r = 0; r < R; r++)
      for (int i = 0; i < D; i++) begin
        m_state[r][i] = 0;
        m_cnt[r][i]   = 0;
      end
    m_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " avail"}, bus.res_avail_o, 0);
    check({tag, " empty"}, bus.empty_o, 2'b11);
    check({tag, " idx"},   bus.alloc_idx_o, 0);
    check({tag, " yumi"},  bus.alloc_yumi_o, 0);
    check({tag, " err"},   bus.err_o, 0);
  endtask

  // One randomized cycle: drive, check combinational outputs, advance model and DUT, check registered outputs.
  task automatic random_cycle(input int cyc);
    int pre [R][D];
    logic [1:0] av, dv, rm;
    logic       rv;
    int refs [R];
    int didx [R];
    int ridx [R];
    int lowest;
    int cand [$];
    logic [D-1:0] exp_av;
    bit exp_empty;

    pre = m_state;
    rv  = ($urandom_range(0, 2) == 0);
    for (int r = 0; r < R; r++) begin
      av[r]   = $urandom_range(0, 1);
      refs[r] = $urandom_range(0, 3);
      dv[r]   = ($urandom_range(0, 2) == 0);
      didx[r] = $urandom_range(0, D - 1);
      cand.delete();
      for (int i = 0; i < D; i++) if (pre[r][i] == 1) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 19) != 0) didx[r] = cand[$urandom_range(0, cand.size() - 1)];
      rm[r]   = $urandom_range(0, 1);
      ridx[r] = $urandom_range(0, D - 1);
      cand.delete();
      for (int i = 0; i < D; i++) if (pre[r][i] == 2) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 19) != 0) ridx[r] = cand[$urandom_range(0, cand.size() - 1)];
      bus.alloc_refs_i[r]  = 4'(refs[r]);
      bus.done_idx_i[r]    = 2'(didx[r]);
      bus.release_idx_i[r] = 2'(ridx[r]);
    end
    bus.alloc_v_i      = av;
    bus.done_v_i       = dv;
    bus.release_v_i    = rv;
    bus.release_mask_i = rm;
    #1;

    for (int r = 0; r < R; r++) begin
      lowest = -1;
      for (int i = D - 1; i >= 0; i--) if (pre[r][i] == 0) lowest = i;
      check($sformatf("rnd%0d yumi r%0d", cyc, r), bus.alloc_yumi_o[r], (av[r] && lowest >= 0) ? 1 : 0);
      if (lowest >= 0) check($sformatf("rnd%0d idx r%0d", cyc, r), bus.alloc_idx_o[r], lowest);
      if (av[r] && lowest >= 0) begin
        m_state[r][lowest] = 1;
`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
        m_cnt[r][lowest] = (refs[r] == 0) ? 1 : refs[r];
`else
        m_cnt[r][lowest] = 1;
`endif
      end
      if (dv[r]) begin
        if (pre[r][didx[r]] == 1) m_state[r][didx[r]] = 2;
        else m_err = 1'b1;
      end
      if (rv && rm[r]) begin
        if (pre[r][ridx[r]] != 2) m_err = 1'b1;
        else if (m_cnt[r][ridx[r]] <= 1) begin
          m_state[r][ridx[r]] = 0;
          m_cnt[r][ridx[r]]   = 0;
        end else m_cnt[r][ridx[r]]--;
      end
    end

    tick();
    for (int r = 0; r < R; r++) begin
      exp_av = '0;
      exp_empty = 1'b1;
      for (int i = 0; i < D; i++) begin
        exp_av[i] = (m_state[r][i] == 2);
        if (m_state[r][i] != 0) exp_empty = 1'b0;
      end
      check($sformatf("rnd%0d avail r%0d", cyc, r), bus.res_avail_o[r], exp_av);
      check($sformatf("rnd%0d empty r%0d", cyc, r), bus.empty_o[r], exp_empty);
    end
    check($sformatf("rnd%0d err", cyc), bus.err_o, m_err);
  endtask

  initial begin
    //            alloc  done   didx  rv    mask   ridx  yumi   avail  empty  chk    idx
    vecs[0]  = '{2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b01, 8'h00, 2'b10, 2'b11, 4'h1};
    vecs[1]  = '{2'b00, 2'b01, 4'h0, 1'b0, 2'b00, 4'h0, 2'b00, 8'h01, 2'b10, 2'b11, 4'h1};
    vecs[2]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b10, 8'h01, 2'b00, 2'b11, 4'h5};
    vecs[3]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b10, 8'h01, 2'b00, 2'b11, 4'h9};
    vecs[4]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b10, 8'h01, 2'b00, 2'b11, 4'hD};
    vecs[5]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b10, 8'h01, 2'b00, 2'b01, 4'h1};
    vecs[6]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b00, 8'h01, 2'b00, 2'b01, 4'h1};
    vecs[7]  = '{2'b00, 2'b10, 4'h8, 1'b0, 2'b00, 4'h0, 2'b00, 8'h41, 2'b00, 2'b01, 4'h1};
    vecs[8]  = '{2'b00, 2'b00, 4'h0, 1'b1, 2'b10, 4'h8, 2'b00, 8'h01, 2'b00, 2'b11, 4'h9};
    vecs[9]  = '{2'b10, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b10, 8'h01, 2'b00, 2'b01, 4'h1};
    vecs[10] = '{2'b00, 2'b10, 4'h8, 1'b0, 2'b00, 4'h0, 2'b00, 8'h41, 2'b00, 2'b01, 4'h1};
    vecs[11] = '{2'b00, 2'b00, 4'h0, 1'b1, 2'b11, 4'h8, 2'b00, 8'h00, 2'b01, 2'b11, 4'h8};
    vecs[12] = '{2'b11, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0, 2'b11, 8'h00, 2'b00, 2'b01, 4'h1};
    vecs[13] = '{2'b00, 2'b11, 4'h8, 1'b0, 2'b00, 4'h0, 2'b00, 8'h41, 2'b00, 2'b01, 4'h1};
    vecs[14] = '{2'b00, 2'b00, 4'h0, 1'b1, 2'b01, 4'h8, 2'b00, 8'h40, 2'b01, 2'b01, 4'h0};

    do_reset();
    check_reset_state("reset");

    // Allocate/complete, full/recovery and multi-resource release as a cycle-by-cycle table.
    for (int k = 0; k < 15; k++) begin
      bus.alloc_v_i      = vecs[k].alloc_v;
      bus.done_v_i       = vecs[k].done_v;
      bus.done_idx_i     = vecs[k].done_idx;
      bus.release_v_i    = vecs[k].rel_v;
      bus.release_mask_i = vecs[k].rel_mask;
      bus.release_idx_i  = vecs[k].rel_idx;
      #1;
      check($sformatf("vec%0d yumi", k), bus.alloc_yumi_o, vecs[k].exp_yumi);
      tick();
      drive_idle();
      check($sformatf("vec%0d avail", k), bus.res_avail_o, vecs[k].exp_avail);
      check($sformatf("vec%0d empty", k), bus.empty_o, vecs[k].exp_empty);
      for (int r = 0; r < R; r++)
        if (vecs[k].chk_idx[r]) check($sformatf("vec%0d idx r%0d", k, r), bus.alloc_idx_o[r], vecs[k].exp_idx[2*r +: 2]);
    end
    check("table err", bus.err_o, 0);

    // Same-cycle alloc and release on a full bank: the freed slot is not reusable until next cycle.
    do_reset();
    bus.alloc_v_i = 2'b01;
    repeat (4) tick();
    drive_idle();
    bus.done_v_i = 2'b01;
    bus.done_idx_i[0] = 2'd3;
    tick();
    drive_idle();
    check("s4 avail", bus.res_avail_o[0], 4'b1000);
    bus.alloc_v_i = 2'b01;
    bus.release_v_i = 1'b1;
    bus.release_mask_i = 2'b01;
    bus.release_idx_i[0] = 2'd3;
    #1;
    check("s4 yumi during release", bus.alloc_yumi_o[0], 0);
    tick();
    drive_idle();
    bus.alloc_v_i = 2'b01;
    #1;
    check("s4 yumi after release", bus.alloc_yumi_o[0], 1);
    check("s4 idx after release", bus.alloc_idx_o[0], 3);
    tick();
    drive_idle();
    check("s4 empty", bus.empty_o, 2'b10);
    check("s4 err", bus.err_o, 0);

    // Done on a free slot: sticky error, no state change.
    do_reset();
    bus.done_v_i = 2'b01;
    bus.done_idx_i[0] = 2'd0;
    tick();
    drive_idle();
    check("s5 err set", bus.err_o, 1);
    check("s5 avail unchanged", bus.res_avail_o, 0);
    check("s5 empty unchanged", bus.empty_o, 2'b11);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("s5 err hold %0d", k), bus.err_o, 1);
    end

    // Done and release on the same pending slot: release is illegal, done still lands.
    do_reset();
    bus.alloc_v_i = 2'b10;
    tick();
    drive_idle();
    bus.done_v_i = 2'b10;
    bus.done_idx_i[1] = 2'd0;
    bus.release_v_i = 1'b1;
    bus.release_mask_i = 2'b10;
    bus.release_idx_i[1] = 2'd0;
    tick();
    drive_idle();
    check("s5 collide err", bus.err_o, 1);
    check("s5 collide avail", bus.res_avail_o[1], 4'b0001);

    // Reset asserted between edges clears everything without a clock edge.
    bus.alloc_v_i = 2'b01;
    tick();
    drive_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

`ifdef BSG_SCHEDULER_RESOURCE_TRACKER_REFCNT_EN
    // Reference counts: three consumers keep the slot ready until the third release.
    do_reset();
    bus.alloc_v_i = 2'b01;
    bus.alloc_refs_i[0] = 4'd3;
    tick();
    drive_idle();
    bus.done_v_i = 2'b01;
    tick();
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      bus.release_v_i = 1'b1;
      bus.release_mask_i = 2'b01;
      bus.release_idx_i[0] = 2'd0;
      tick();
      drive_idle();
      check($sformatf("rc release%0d avail", k), bus.res_avail_o[0], (k < 2) ? 4'b0001 : 4'b0000);
    end
    check("rc freed empty", bus.empty_o[0], 1);
    check("rc freed idx", bus.alloc_idx_o[0], 0);
    bus.alloc_v_i = 2'b01;
    bus.alloc_refs_i[0] = 4'd0;
    tick();
    drive_idle();
    bus.done_v_i = 2'b01;
    tick();
    drive_idle();
    bus.release_v_i = 1'b1;
    bus.release_mask_i = 2'b01;
    tick();
    drive_idle();
    check("rc zero refs freed", bus.empty_o[0], 1);
    check("rc zero refs avail", bus.res_avail_o[0], 0);
    check("rc err", bus.err_o, 0);
`else
    // Without counts the first release frees the slot whatever refs said.
    do_reset();
    bus.alloc_v_i = 2'b01;
    bus.alloc_refs_i[0] = 4'd3;
    tick();
    drive_idle();
    bus.done_v_i = 2'b01;
    tick();
    drive_idle();
    bus.release_v_i = 1'b1;
    bus.release_mask_i = 2'b01;
    tick();
    drive_idle();
    check("norc first release avail", bus.res_avail_o[0], 0);
    check("norc first release empty", bus.empty_o[0], 1);
    check("norc err", bus.err_o, 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) random_cycle(c);
    drive_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
